scmp_bus_ctl: RTL and testbench



---
 rtl/scmp_bus_pak.sv | 41 ++++
 rtl/scmp_bus_ctl.sv | 143 ++++++++++++++
 tb/tb_scmp_bus_ctl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/scmp_bus_pak.sv
// Shared types and data-bus multiplex positions for the SC/MP external bus-cycle controller.
package scmp_bus_pak;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    STROBE,
    DONE,
    RECOVER
  } BUS_STATE_t;

  // Field order matches the microcode bus[6:3] flag group.
  typedef struct packed {
    logic h;
    logic d;
    logic i;
    logic r;
  } BUS_FLAGS_t;

  localparam int DOUT_FLAGS_LSB = 4;
  localparam int DOUT_AHI_LSB   = 0;
  localparam int ADDR_HI_LSB    = 12;
  localparam int ADDR_LO_W      = 12;

  // Address-phase byte: flags in the upper nibble, A15..A12 in the lower nibble.
  function automatic logic [7:0] addr_phase_byte(input BUS_FLAGS_t flags,
                                                 input logic [15:0] addr);
    logic [7:0] b;
    b = '0;
    b[DOUT_FLAGS_LSB +: 4] = flags;
    b[DOUT_AHI_LSB +: 4]   = addr[ADDR_HI_LSB +: 4];
    return b;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/scmp_bus_ctl.sv
// External bus-cycle controller: turns microcode bus requests into NADS/NRDS/NWDS cycles
// and stalls the microcode PC until the data phase has completed.
module scmp_bus_ctl
  import scmp_bus_pak::*;
#(
  parameter int ADS_CYCLES     = 1,
  parameter int STROBE_CYCLES  = 2,
  parameter int RECOVER_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_ads,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [3:0]  req_flags,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        rdata_valid,
  output logic        stall,
  input  logic        ext_enin,
  input  logic        ext_hold,
  input  logic [7:0]  ext_din,
  output logic [11:0] ext_addr,
  output logic [7:0]  ext_dout,
  output logic        ext_dout_oe,
  output logic        ext_nads,
  output logic        ext_nrds,
  output logic        ext_nwds
);

  localparam int CNT_W = $clog2(max3(ADS_CYCLES, STROBE_CYCLES, RECOVER_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] ADS_LOAD = CNT_W'(ADS_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'((RECOVER_CYCLES > 0) ? RECOVER_CYCLES - 1 : 0);

  BUS_STATE_t       state;
  logic [CNT_W-1:0] cnt;
  logic             lat_rd;
  logic             lat_wr;
  logic [7:0]       lat_wdata;

  // The microcode PC is frozen while a cycle is in flight or a new request is waiting;
  // only DONE lets it advance.
  assign stall = ((state == IDLE) && req_ads)
               || ((state inside {ADDR, STROBE, RECOVER}) && req_ads)
               || (state inside {ADDR, STROBE});

  // Single FSM with a shared down-counter: it is loaded with (phase length - 1) on entry and
  // sticks at zero, so a held strobe simply waits at zero until ext_hold drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_rd      <= 1'b0;
      lat_wr      <= 1'b0;
      lat_wdata   <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      ext_addr    <= '0;
      ext_dout    <= '0;
      ext_dout_oe <= 1'b0;
      ext_nads    <= 1'b1;
      ext_nrds    <= 1'b1;
      ext_nwds    <= 1'b1;
    end else begin
      rdata_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_ads && ext_enin) begin
            state       <= ADDR;
            cnt         <= ADS_LOAD;
            lat_rd      <= req_rd;
            lat_wr      <= req_wr & ~req_rd;
            lat_wdata   <= wdata;
            ext_nads    <= 1'b0;
            ext_dout_oe <= 1'b1;
            ext_dout    <= addr_phase_byte(BUS_FLAGS_t'(req_flags), addr);
            ext_addr    <= addr[ADDR_LO_W-1:0];
          end
        end

        ADDR: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            ext_nads <= 1'b1;
            if (lat_rd || lat_wr) begin
              state <= STROBE;
              cnt   <= STB_LOAD;
              if (lat_rd) begin
                ext_nrds    <= 1'b0;
                ext_dout_oe <= 1'b0;
              end else begin
                ext_nwds    <= 1'b0;
                ext_dout_oe <= 1'b1;
                ext_dout    <= lat_wdata;
              end
            end else begin
              state       <= DONE;
              ext_dout_oe <= 1'b0;
            end
          end
        end

        STROBE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!ext_hold) begin
            state    <= DONE;
            ext_nrds <= 1'b1;
            ext_nwds <= 1'b1;
            if (lat_rd) begin
              rdata       <= ext_din;
              rdata_valid <= 1'b1;
            end
          end
        end

        DONE: begin
          ext_dout_oe <= 1'b0;
          if (RECOVER_CYCLES > 0) begin
            state <= RECOVER;
            cnt   <= REC_LOAD;
          end else begin
            state <= IDLE;
          end
        end

        RECOVER: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scmp_bus_ctl.sv
// Self-checking bench for scmp_bus_ctl: directed scenarios plus randomized transactions
// compared against a cycle-timeline model of the bus protocol.
module tb_scmp_bus_ctl;

  localparam int ADS = 1;
  localparam int STB = 2;
  localparam int REC = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_ads, req_rd, req_wr;
  logic [3:0]  req_flags;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rdata_valid, stall;
  logic        ext_enin, ext_hold;
  logic [7:0]  ext_din;
  logic [11:0] ext_addr;
  logic [7:0]  ext_dout;
  logic        ext_dout_oe, ext_nads, ext_nrds, ext_nwds;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         lastDone = 0;
  bit         chainPending = 1'b0;
  logic [7:0] expRdata = 8'h00;

  always #5 clk = ~clk;

  scmp_bus_ctl #(.ADS_CYCLES(ADS), .STROBE_CYCLES(STB), .RECOVER_CYCLES(REC)) dut (
    .clk(clk), .rst(rst),
    .req_ads(req_ads), .req_rd(req_rd), .req_wr(req_wr), .req_flags(req_flags),
    .addr(addr), .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid), .stall(stall),
    .ext_enin(ext_enin), .ext_hold(ext_hold), .ext_din(ext_din),
    .ext_addr(ext_addr), .ext_dout(ext_dout), .ext_dout_oe(ext_dout_oe),
    .ext_nads(ext_nads), .ext_nrds(ext_nrds), .ext_nwds(ext_nwds)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic applyStimulus(input bit ads, input bit rd, input bit wr,
                               input logic [3:0] fl, input logic [15:0] a,
                               input logic [7:0] wd, input bit enin, input bit hold,
                               input logic [7:0] din);
    req_ads   = ads;
    req_rd    = rd;
    req_wr    = wr;
    req_flags = fl;
    addr      = a;
    wdata     = wd;
    ext_enin  = enin;
    ext_hold  = hold;
    ext_din   = din;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Model: a request accepted in cycle 'accept' gives ADS address cycles, then STB+holdExtra
  // strobe cycles (none if address-only), one DONE cycle and REC recovery cycles.
  task automatic runTxn(input bit rd, input bit wr, input logic [3:0] fl,
                        input logic [15:0] a16, input logic [7:0] wd, input logic [7:0] din,
                        input int grantDelay, input int holdExtra, input bit chain,
                        input string name);
    bit   isRd, isWr, strobed, prevChain;
    bit   inAddr, inStb, isDone, hold, eOe;
    int   accept, s, len, d, total;
    logic [7:0] dinv;
    isRd      = rd;
    isWr      = wr & ~rd;
    strobed   = rd | wr;
    prevChain = chainPending;
    accept    = grantDelay;
    s         = accept + ADS + 1;
    len       = strobed ? STB + holdExtra : 0;
    d         = s + len;
    total     = d + REC;
    for (int k = 0; k <= total; k++) begin
      inAddr = (k > accept) && (k <= accept + ADS);
      inStb  = strobed && (k >= s) && (k < s + len);
      isDone = (k == d);
      hold   = strobed && (k >= s + STB - 1) && (k < s + STB - 1 + holdExtra);
      dinv   = inStb ? din : 8'($urandom);
      if (k <= accept)
        applyStimulus(1'b1, rd, wr, fl, a16, wd, k >= accept, 1'b0, dinv);
      else
        applyStimulus((k <= d) || chain, rd, wr, 4'($urandom), 16'($urandom),
                      8'($urandom), 1'b1, hold, dinv);
      #1;
      if (isDone) begin
        lastDone = cyc;
        if (isRd) expRdata = din;
      end
      if (k == accept + 1 && prevChain && grantDelay == 0)
        checkOutput({name, "_b2b_gap"}, 16'(cyc - lastDone), 16'(REC + 2));
      eOe = inAddr || ((inStb || isDone) && isWr);
      checkOutput({name, "_stall"}, 16'(stall), 16'((k < d) || (k > d && chain)));
      checkOutput({name, "_nads"}, 16'(ext_nads), 16'(!inAddr));
      checkOutput({name, "_nrds"}, 16'(ext_nrds), 16'(!(inStb && isRd)));
      checkOutput({name, "_nwds"}, 16'(ext_nwds), 16'(!(inStb && isWr)));
      checkOutput({name, "_oe"}, 16'(ext_dout_oe), 16'(eOe));
      checkOutput({name, "_rvalid"}, 16'(rdata_valid), 16'(isDone && isRd));
      checkOutput({name, "_rdata"}, 16'(rdata), 16'(expRdata));
      if (inAddr)
        checkOutput({name, "_dout_addr"}, 16'(ext_dout), 16'({fl, a16[15:12]}));
      else if ((inStb || isDone) && isWr)
        checkOutput({name, "_dout_wr"}, 16'(ext_dout), 16'(wd));
      if (k > accept && k <= d)
        checkOutput({name, "_addr"}, 16'(ext_addr), 16'(a16[11:0]));
      tick();
    end
    chainPending = chain;
  endtask

  initial begin
    bit         rrd, rwr, rchain;
    int         rgrant, rhold;

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 8'h00, 1'b1, 1'b0, 8'h00);
    tick();
    tick();
    checkOutput("rst_nads", 16'(ext_nads), 16'd1);
    checkOutput("rst_nrds", 16'(ext_nrds), 16'd1);
    checkOutput("rst_nwds", 16'(ext_nwds), 16'd1);
    checkOutput("rst_oe", 16'(ext_dout_oe), 16'd0);
    checkOutput("rst_addr", 16'(ext_addr), 16'd0);
    checkOutput("rst_dout", 16'(ext_dout), 16'd0);
    checkOutput("rst_rdata", 16'(rdata), 16'd0);
    checkOutput("rst_rvalid", 16'(rdata_valid), 16'd0);
    checkOutput("rst_stall", 16'(stall), 16'd0);
    rst = 1'b0;
    tick();

    runTxn(1'b1, 1'b0, 4'b0101, 16'hA123, 8'h00, 8'h5C, 0, 0, 1'b0, "rd_default");
    runTxn(1'b0, 1'b1, 4'b1010, 16'h4F00, 8'h3E, 8'h00, 0, 3, 1'b0, "wr_hold");
    runTxn(1'b1, 1'b0, 4'b0011, 16'h7777, 8'h00, 8'hC3, 4, 0, 1'b0, "grant_wait");
    runTxn(1'b1, 1'b0, 4'b1001, 16'h1234, 8'h00, 8'h81, 0, 0, 1'b1, "b2b_first");
    runTxn(1'b0, 1'b1, 4'b0110, 16'hBEEF, 8'h42, 8'h00, 0, 0, 1'b0, "b2b_second");
    runTxn(1'b1, 1'b1, 4'b1111, 16'h0F0F, 8'h99, 8'hE7, 0, 1, 1'b0, "rd_wr_both");
    runTxn(1'b0, 1'b0, 4'b1100, 16'h9ABC, 8'h11, 8'h00, 0, 0, 1'b0, "addr_only");

    // Reset pulsed during the first strobe cycle of a read.
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h3, 16'h5678, 8'h00, 1'b1, 1'b0, 8'hAA);
    tick();
    tick();
    #1;
    checkOutput("mid_rst_in_strobe", 16'(ext_nrds), 16'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 8'h00, 1'b1, 1'b0, 8'hAA);
    #1;
    expRdata = 8'h00;
    checkOutput("mid_rst_nrds", 16'(ext_nrds), 16'd1);
    checkOutput("mid_rst_nads", 16'(ext_nads), 16'd1);
    checkOutput("mid_rst_nwds", 16'(ext_nwds), 16'd1);
    checkOutput("mid_rst_oe", 16'(ext_dout_oe), 16'd0);
    checkOutput("mid_rst_rdata", 16'(rdata), 16'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("mid_rst_rvalid", 16'(rdata_valid), 16'd0);
      checkOutput("mid_rst_idle_nrds", 16'(ext_nrds), 16'd1);
      tick();
    end

    for (int t = 0; t < 24; t++) begin
      rrd    = 1'($urandom_range(0, 1));
      rwr    = 1'($urandom_range(0, 1));
      rgrant = chainPending ? 0 : int'($urandom_range(0, 3));
      rhold  = int'($urandom_range(0, 3));
      rchain = (t < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
      runTxn(rrd, rwr, 4'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
             rgrant, rhold, rchain, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL timeout cycle=%0d observed=running expected=finished", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] timeout");
  end

endmodule
